// File: rtl/ip_hdr_tx_ctrl_if.sv
// Header byte stream between the IPv4 header sequencer and the Ethernet framer.
interface ip_hdr_tx_ctrl_if;
  logic [7:0] hdr_byte;
  logic       hdr_valid;
  logic       hdr_last;
  logic       hdr_ready;

  modport master (
    output hdr_byte,
    output hdr_valid,
    output hdr_last,
    input  hdr_ready
  );

  modport slave (
    input  hdr_byte,
    input  hdr_valid,
    input  hdr_last,
    output hdr_ready
  );
endinterface

// File: rtl/ip_hdr_tx_ctrl.sv
// IPv4 header sequencer: latches a request, runs the shared checksum unit once,
// then streams the 20-byte header (checksum included) over a valid/ready link.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; length check and ID/length capture
// CALC  | cs_cal_en high for one cycle, checksum unit registers its sum
// WAIT  | checksum output valid, captured at the end of this cycle
// SEND  | bytes 0..19 presented, index advances on valid && ready
module ip_hdr_tx_ctrl #(
  parameter logic [31:0] SRC_IP   = 32'hC0A80001,
  parameter logic [31:0] DST_IP   = 32'hC0A800C7,
  parameter logic [7:0]  TTL      = 8'd64,
  parameter logic [7:0]  PROTOCOL = 8'd17
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [15:0]        payload_len,
  output logic               busy,
  output logic               len_err,
  output logic               done,
  output logic               cs_cal_en,
  output logic [15:0]        cs_total_len,
  output logic [15:0]        cs_id,
  input  logic [15:0]        cs_checksum,
  ip_hdr_tx_ctrl_if.master   hdr
);

  // Largest payload whose total length still fits in 16 bits.
  localparam logic [15:0] MAX_PAYLOAD = 16'd65515;
  localparam logic [4:0]  LAST_IDX    = 5'd19;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_WAIT,
    S_SEND
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q;
  logic [15:0] pkt_id_q;
  logic [15:0] csum_q;
  logic [15:0] total_len_q;
  logic [15:0] id_q;
  logic        len_err_q;
  logic        done_q;
  logic        take_req;
  logic        reject;
  logic        byte_acc;
  logic        hdr_end;
  logic [7:0]  byte_mux;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and control strobes.
  always_comb begin
    state_d  = state_q;
    take_req = 1'b0;
    reject   = 1'b0;
    byte_acc = 1'b0;
    hdr_end  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (payload_len > MAX_PAYLOAD) begin
            reject = 1'b1;
          end else begin
            take_req = 1'b1;
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: state_d = S_WAIT;
      S_WAIT: state_d = S_SEND;
      S_SEND: begin
        byte_acc = hdr.hdr_ready;
        if (hdr.hdr_ready && (idx_q == LAST_IDX)) begin
          hdr_end = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, checksum capture, byte index and packet ID.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q       <= '0;
      pkt_id_q    <= '0;
      csum_q      <= '0;
      total_len_q <= '0;
      id_q        <= '0;
      len_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      len_err_q <= reject;
      done_q    <= hdr_end;
      if (take_req) begin
        total_len_q <= payload_len + 16'd20;
        id_q        <= pkt_id_q;
      end
      if (state_q == S_WAIT) begin
        csum_q <= cs_checksum;
        idx_q  <= '0;
      end else if (byte_acc) begin
        idx_q <= hdr_end ? 5'd0 : idx_q + 5'd1;
      end
      if (hdr_end) pkt_id_q <= pkt_id_q + 16'd1;
    end
  end

  // Header byte selection, network order.
  always_comb begin
    byte_mux = 8'h00;
    case (idx_q)
      5'd0:  byte_mux = 8'h45;
      5'd1:  byte_mux = 8'h00;
      5'd2:  byte_mux = total_len_q[15:8];
      5'd3:  byte_mux = total_len_q[7:0];
      5'd4:  byte_mux = id_q[15:8];
      5'd5:  byte_mux = id_q[7:0];
      5'd6:  byte_mux = 8'h40;
      5'd7:  byte_mux = 8'h00;
      5'd8:  byte_mux = TTL;
      5'd9:  byte_mux = PROTOCOL;
      5'd10: byte_mux = csum_q[15:8];
      5'd11: byte_mux = csum_q[7:0];
      5'd12: byte_mux = SRC_IP[31:24];
      5'd13: byte_mux = SRC_IP[23:16];
      5'd14: byte_mux = SRC_IP[15:8];
      5'd15: byte_mux = SRC_IP[7:0];
      5'd16: byte_mux = DST_IP[31:24];
      5'd17: byte_mux = DST_IP[23:16];
      5'd18: byte_mux = DST_IP[15:8];
      5'd19: byte_mux = DST_IP[7:0];
      default: byte_mux = 8'h00;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign cs_cal_en    = (state_q == S_CALC);
  assign len_err      = len_err_q;
  assign done         = done_q;
  assign cs_total_len = total_len_q;
  assign cs_id        = id_q;

  assign hdr.hdr_valid = (state_q == S_SEND);
  assign hdr.hdr_last  = (state_q == S_SEND) && (idx_q == LAST_IDX);
  assign hdr.hdr_byte  = (state_q == S_SEND) ? byte_mux : 8'h00;

endmodule

// File: tb/tb_ip_hdr_tx_ctrl.sv
// Scoreboard bench for ip_hdr_tx_ctrl with a behavioural checksum unit.
module tb_ip_hdr_tx_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] payload_len;
  logic        busy, len_err, done, cs_cal_en;
  logic [15:0] cs_total_len, cs_id, cs_checksum;

  ip_hdr_tx_ctrl_if hdr_if ();

  ip_hdr_tx_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .payload_len  (payload_len),
    .busy         (busy),
    .len_err      (len_err),
    .done         (done),
    .cs_cal_en    (cs_cal_en),
    .cs_total_len (cs_total_len),
    .cs_id        (cs_id),
    .cs_checksum  (cs_checksum),
    .hdr          (hdr_if.master)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  bit         bp_mode = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checksum unit: ver/ihl=45, tos=0, df=1, ttl=64, proto=17, fixed addresses.
  function automatic logic [15:0] ip_csum(input logic [15:0] tl, input logic [15:0] id);
    logic [31:0] s;
    s = 32'h4500 + {16'h0, tl} + {16'h0, id} + 32'h4000 + 32'h4011
      + 32'hC0A8 + 32'h0001 + 32'hC0A8 + 32'h00C7;
    s = (s & 32'hFFFF) + (s >> 16);
    s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  logic [15:0] cs_sum_q;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)       cs_sum_q <= 16'h0;
    else if (cs_cal_en) cs_sum_q <= ip_csum(cs_total_len, cs_id);
  end
  assign cs_checksum = cs_sum_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input logic [15:0] tl, input logic [15:0] id, input logic [15:0] cs);
    logic [7:0] b[20];
    b = '{8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0], 8'h40, 8'h00,
          8'h40, 8'h11, cs[15:8], cs[7:0], 8'hC0, 8'hA8, 8'h00, 8'h01,
          8'hC0, 8'hA8, 8'h00, 8'hC7};
    for (int i = 0; i < 20; i++) exp_q.push_back({(i == 19), b[i]});
  endtask

  // Ready source: constant high, or pseudo-random in backpressure mode.
  initial begin
    hdr_if.hdr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      hdr_if.hdr_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each accepted byte, checks hold and per-packet counts.
  logic [7:0] prev_byte;
  logic       prev_last;
  bit         pend_stall, in_hdr;
  int         pop_cnt, cal_cnt;
  logic [8:0] mon_e;
  always @(negedge clk) begin
    if (!reset_n) begin
      pend_stall = 1'b0;
      in_hdr     = 1'b0;
      pop_cnt    = 0;
      cal_cnt    = 0;
    end else begin
      if (cs_cal_en) cal_cnt++;
      if (in_hdr || pend_stall) chk("valid_held", hdr_if.hdr_valid, 1);
      if (pend_stall) begin
        chk("hold_byte", hdr_if.hdr_byte, prev_byte);
        chk("hold_last", hdr_if.hdr_last, prev_last);
      end
      if (hdr_if.hdr_valid && hdr_if.hdr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", hdr_if.hdr_byte, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("hdr_byte", hdr_if.hdr_byte, mon_e[7:0]);
          chk("hdr_last", hdr_if.hdr_last, mon_e[8]);
          in_hdr = !hdr_if.hdr_last;
        end
        pop_cnt++;
      end
      pend_stall = hdr_if.hdr_valid && !hdr_if.hdr_ready;
      prev_byte  = hdr_if.hdr_byte;
      prev_last  = hdr_if.hdr_last;
      if (done) begin
        chk("cal_en_per_pkt", cal_cnt, 1);
        chk("bytes_per_pkt", pop_cnt, 20);
        cal_cnt = 0;
        pop_cnt = 0;
      end
    end
  end

  // Full-rate packet with cycle-exact checks; returns in the done cycle (23).
  task automatic timed_pkt(input logic [15:0] len, input logic [15:0] tl,
                           input logic [15:0] id, input logic [15:0] cs);
    push_hdr(tl, id, cs);
    start = 1'b1;
    payload_len = len;
    tick;
    start = 1'b0;
    chk("c1_cal_en", cs_cal_en, 1);
    chk("c1_busy", busy, 1);
    chk("c1_total_len", cs_total_len, tl);
    chk("c1_id", cs_id, id);
    tick;
    chk("c2_cal_en", cs_cal_en, 0);
    chk("c2_valid", hdr_if.hdr_valid, 0);
    tick;
    chk("c3_valid", hdr_if.hdr_valid, 1);
    repeat (18) tick;
    chk("c21_last", hdr_if.hdr_last, 0);
    tick;
    chk("c22_last", hdr_if.hdr_last, 1);
    chk("c22_done", done, 0);
    tick;
    chk("c23_done", done, 1);
    chk("c23_busy", busy, 0);
    chk("hold_total_len", cs_total_len, tl);
    chk("hold_id", cs_id, id);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick;
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    repeat (2) tick;
    reset_n = 1'b1;
    tick;
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    payload_len = 16'd0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_done", done, 0);
    chk("rst_cal_en", cs_cal_en, 0);
    chk("rst_valid", hdr_if.hdr_valid, 0);
    chk("rst_last", hdr_if.hdr_last, 0);
    chk("rst_byte", hdr_if.hdr_byte, 0);
    chk("rst_total_len", cs_total_len, 0);
    chk("rst_id", cs_id, 0);
    repeat (2) tick;
    reset_n = 1'b1;
    tick;

    // Reference header, then back-to-back with start in the done cycle.
    timed_pkt(16'd95, 16'h0073, 16'h0000, 16'hB861);
    timed_pkt(16'd95, 16'h0073, 16'h0001, 16'hB860);
    tick;

    // Backpressure after a reset: same stream as the reference.
    do_reset;
    push_hdr(16'h0073, 16'h0000, 16'hB861);
    bp_mode = 1'b1;
    start = 1'b1;
    payload_len = 16'd95;
    tick;
    start = 1'b0;
    wait_done(400);
    bp_mode = 1'b0;
    repeat (2) tick;

    // Length boundary: largest accepted, then first rejected.
    timed_pkt(16'd65515, 16'hFFFF, 16'h0001, 16'hB8D3);
    tick;
    start = 1'b1;
    payload_len = 16'd65516;
    tick;
    start = 1'b0;
    chk("rej_len_err", len_err, 1);
    chk("rej_busy", busy, 0);
    chk("rej_cal_en", cs_cal_en, 0);
    chk("rej_hold_total_len", cs_total_len, 16'hFFFF);
    chk("rej_hold_id", cs_id, 16'h0001);
    tick;
    chk("rej_len_err_pulse", len_err, 0);
    chk("rej_busy2", busy, 0);
    tick;

    // Start held during the whole busy period is ignored; ID unchanged by reject.
    push_hdr(16'h0073, 16'h0002, 16'hB85F);
    start = 1'b1;
    payload_len = 16'd95;
    tick;
    chk("bs_cal_en", cs_cal_en, 1);
    chk("bs_id", cs_id, 16'h0002);
    payload_len = 16'hFFFF;
    for (int c = 2; c <= 21; c++) begin
      tick;
      chk("bs_no_len_err", len_err, 0);
    end
    start = 1'b0;
    payload_len = 16'd95;
    tick;
    tick;
    chk("bs_done", done, 1);
    tick;
    chk("bs_not_requeued", busy, 0);
    chk("bs_no_cal", cs_cal_en, 0);
    tick;

    // Reset while byte 7 is presented: partial header dropped.
    push_hdr(16'h0073, 16'h0003, 16'hB85E);
    start = 1'b1;
    payload_len = 16'd95;
    tick;
    start = 1'b0;
    repeat (9) tick;
    chk("mid_valid", hdr_if.hdr_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", hdr_if.hdr_valid, 0);
    chk("mid_rst_byte", hdr_if.hdr_byte, 0);
    chk("mid_rst_total_len", cs_total_len, 0);
    chk("mid_rst_id", cs_id, 0);
    chk("mid_rst_done", done, 0);
    exp_q.delete();
    tick;
    reset_n = 1'b1;
    tick;
    timed_pkt(16'd95, 16'h0073, 16'h0000, 16'hB861);
    tick;

    // ID wrap from 0xFFFF to 0x0000.
    force dut.pkt_id_q = 16'hFFFF;
    tick;
    release dut.pkt_id_q;
    tick;
    timed_pkt(16'd95, 16'h0073, 16'hFFFF, 16'hB861);
    timed_pkt(16'd95, 16'h0073, 16'h0000, 16'hB861);
    repeat (3) tick;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_hdr_tx_ctrl.md
# ip_hdr_tx_ctrl

Sequencer that builds and streams a 20-byte IPv4 header for the UDP GMII transmit path. On a start request it latches the payload length, drives the shared IP checksum unit through one calculation, and captures the result. It then serialises the complete header, checksum included, as a byte stream with a valid/ready handshake. It sits between the packet scheduler, which issues `start`, and the Ethernet framer, which consumes `hdr_byte`.

## Interface
- `SRC_IP`, 32'hC0A80001, source address; sent in header bytes 12-15.
- `DST_IP`, 32'hC0A800C7, destination address; sent in header bytes 16-19.
- `TTL`, 8'd64, time to live.
- `PROTOCOL`, 8'd17, protocol field (UDP).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one header; sampled only in IDLE.
- `payload_len`  in  16  IP payload bytes (UDP header + data); sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `len_err`  out  1  one-cycle pulse: request rejected, `payload_len` > 65515.
- `done`  out  1  one-cycle pulse after the last header byte is accepted.
- `cs_cal_en`  out  1  to checksum unit `cal_en`.
- `cs_total_len`  out  16  to checksum unit `IP_total_len`.
- `cs_id`  out  16  to checksum unit `IP_id`.
- `cs_checksum`  in  16  from checksum unit `checksum`.
- `hdr_byte`  out  8  header byte.
- `hdr_valid`  out  1  `hdr_byte` is valid.
- `hdr_last`  out  1  marks byte 19.
- `hdr_ready`  in  1  consumer accepts the byte on `hdr_valid && hdr_ready`.

Checksum unit constant inputs are tied at integration: ver=4, hdr_len=5, tos=0, rsv=0, df=1, mf=0, frag_offset=0. ttl, protocol, src_ip and dst_ip are tied to this block's parameters.

## Operation
- **States:** IDLE, CALC, WAIT, SEND.
- **IDLE + `start`, `payload_len` ≤ 65515:**
  - latch `total_len` = `payload_len` + 20;
  - `cs_total_len` = `total_len`; `cs_id` = the current packet ID;
  - go to CALC.
- **IDLE + `start`, `payload_len` > 65515:** pulse `len_err` for one cycle; stay in IDLE; packet ID unchanged.
- **CALC:** `cs_cal_en` = 1 for exactly one cycle; go to WAIT.
- **WAIT:** register `cs_checksum` into an internal checksum register at the end of this cycle; go to SEND.
- **SEND:**
  - 5-bit byte index 0..19, cleared on entry;
  - index advances only on `hdr_valid && hdr_ready`;
  - after byte 19 is accepted: go to IDLE, pulse `done`, packet ID += 1 (16-bit wrap, 0xFFFF→0x0000).
- **Byte order** (network, MSB first):
  - bytes 0-3: 0x45, 0x00, `total_len`[15:8], `total_len`[7:0];
  - bytes 4-7: id[15:8], id[7:0], 0x40, 0x00;
  - bytes 8-11: `TTL`, `PROTOCOL`, checksum[15:8], checksum[7:0];
  - bytes 12-19: `SRC_IP` then `DST_IP`, MSB first.
- **Handshake:** `hdr_byte` and `hdr_last` are held stable while `hdr_valid` && !`hdr_ready`. `hdr_valid` never drops mid-header.
- **Holding:** `cs_total_len` and `cs_id` hold their values from CALC entry until `done`, and keep them in IDLE.
- **Busy:** `start` is ignored while `busy`; it is neither queued nor flagged.
- **Reset** (also mid-operation): all registers clear and the FSM returns to IDLE. A partial header is abandoned; no `done`.

## Timing
- **Reset values:**
  - `busy`, `len_err`, `done`, `cs_cal_en`, `hdr_valid`, `hdr_last` = 0;
  - `hdr_byte`, `cs_total_len`, `cs_id` = 0;
  - packet ID = 0; FSM = IDLE.
- **Start sequence:** `start` sampled at edge 0 → CALC, with `cs_cal_en` = 1 and `busy` = 1, in cycle 1.
  - The checksum unit registers its sum at edge 1; its combinational output is valid in cycle 2 (WAIT) and is captured at edge 2.
  - `hdr_valid` = 1 with byte 0 in cycle 3.
- **Throughput:** with `hdr_ready` held high, bytes 0-19 appear in cycles 3-22, with `hdr_last` in cycle 22.
- **Completion:** `done` = 1 and `busy` = 0 in cycle 23. A new `start` may be sampled in cycle 23.
- **Latency:** minimum start-to-start period is 23 cycles.
- **Rejection:** `len_err` goes high in the cycle after the rejected `start` is sampled.

## Test plan
- **Reference header:** reset, then `payload_len` = 95, `hdr_ready` = 1, real checksum unit in the bench.
  - Required stream: 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7.
  - `hdr_last` on byte 19 in cycle 22; `done` in cycle 23.
- **Back-to-back:** second request, same length, `start` in the `done` cycle.
  - id bytes = 00 01; checksum = 0xB860.
  - `cs_cal_en` asserted exactly once per packet.
- **Backpressure:** `hdr_ready` toggled pseudo-randomly.
  - Every byte held stable until accepted; the stream is identical to the first scenario; no byte lost or duplicated.
- **Length boundary:**
  - `payload_len` = 65515 → `total_len` bytes FF FF;
  - `payload_len` = 65516 → `len_err` pulse, `busy` stays 0, no `cs_cal_en`, next packet ID unchanged.
- **Busy `start`:** `start` asserted every cycle during SEND → ignored; exactly one header emitted.
- **Reset and ID wrap:**
  - `reset_n` low at byte 7 → outputs cleared immediately; the next packet uses id 0x0000.
  - Preload 65535 packets (or force the ID to 0xFFFF) → the following packet uses 0x0000.
